gb_timer_unit: RTL and testbench
================================

// Module: gb_timer_unit
// PURPOSE
//  DMG timer block: 16-bit system counter (DIV), TIMA/TMA/TAC registers and the
//  timer interrupt request. Sits directly downstream of the clock divider stage.
//  Runs on the single fast system clock. Advances only on tick_en pulses, one per
//  Game Boy T-cycle (4.194304 MHz equivalent). CPU bus decode sits above it; irq
//  goes to the interrupt controller (IF bit 2).
// PARAMETERS
//  CNT_WIDTH        16  internal system counter width; DIV = cnt[15:8]
//  OVF_DELAY_TICKS  4   ticks between TIMA overflow and TMA reload/irq
// PORTS
//  clock      in   1   system clock, all logic on posedge
//  reset      in   1   synchronous, active-high
//  tick_en    in   1   one-clock enable pulse per T-cycle, from divider stage
//  reg_sel    in   2   0=DIV(FF04) 1=TIMA(FF05) 2=TMA(FF06) 3=TAC(FF07)
//  wr_en      in   1   write strobe; one clock wide; acts regardless of tick_en
//  wdata      in   8   write data
//  rdata      out  8   registered read data for reg_sel, valid 1 clock after sel
//  irq_timer  out  1   one-clock pulse on TMA reload after overflow
// BEHAVIOUR
//  Reset: cnt=0, TIMA=0, TMA=0, TAC=0, state=RUN, delay=0, rdata=0, irq_timer=0.
//  cnt: +1 (mod 2^16) on each tick_en. Write to DIV (any data) clears cnt to 0.
//   DIV write wins over same-clock tick.
//  Select bit: TAC[1:0] 00->cnt[9] 01->cnt[3] 10->cnt[5] 11->cnt[7].
//   Enable is TAC[2].
//  inc_sig = TAC[2] & cnt[sel]. Keep its previous value in a flop.
//   TIMA increments on every 1->0 edge of inc_sig. This includes edges caused by
//   a DIV write, a TAC select change, or clearing TAC[2] (DMG glitch behaviour).
//  TIMA write in RUN: loads wdata and suppresses a same-clock increment.
//  State machine (tick_en-gated except where noted):
//   RUN   : increment of 0xFF -> TIMA=0x00, delay=OVF_DELAY_TICKS-1, go OVF.
//   OVF   : TIMA reads 0x00 (unless written). Decrement delay each tick.
//           delay==0 on a tick -> TIMA=TMA, irq_timer=1 for one clock, go RUN.
//           TIMA write in OVF -> TIMA=wdata, cancel reload and irq, go RUN.
//           Increments during OVF are applied to TIMA normally.
//   Reload clock: TMA write on the same clock -> new TMA value is loaded.
//           TIMA write on the same clock -> ignored; TMA wins.
//  TMA write: loads wdata any time. TAC write: stores wdata[2:0].
//  Read map: DIV=cnt[15:8], TIMA, TMA, TAC reads {5'b11111, TAC[2:0]}.
//   Writes only take effect when wr_en=1. Reads have no side effects.
//  Reset asserted mid-OVF: returns to RUN. Any pending irq is dropped.
//  irq_timer never asserts for two consecutive clocks.
// STRUCTURE
//  Shared package gb_timer_pkg holds:
//   - register offset localparams REG_DIV/REG_TIMA/REG_TMA/REG_TAC;
//   - state enum {RUN, OVF};
//   - TAC select-bit table function tac_bit_idx(TAC[1:0]).
//  One natural sub-module: gb_timer_edge_det. It holds the inc_sig flop and emits
//   the 1->0 pulse. Everything else stays flat in gb_timer_unit.
// TESTING
//  1 Reset, tick_en every clock, 512 ticks -> DIV reads 0x02. TIMA stays 0x00
//    (TAC=0).
//  2 TAC=0x05, TIMA=0x00, 160 ticks -> TIMA=0x0A. DIV write with cnt[3]=1 ->
//    TIMA=0x0B on the next clock.
//  3 TAC=0x05, TMA=0x80, TIMA=0xFE, 32 ticks -> TIMA=0x00. 4 ticks later
//    TIMA=0x80, and irq_timer is high for exactly 1 clock.
//  4 Overflow as in 3, then TIMA write 0x33 on 2nd OVF tick -> TIMA=0x33, no irq,
//    no reload.
//  5 Overflow as in 3; TMA write 0x44 and TIMA write 0x55 on the reload clock ->
//    TIMA=0x44, irq pulsed once.
//  6 TAC=0x04 with cnt[9]=1, then write TAC=0x00 -> TIMA +1. Read TAC -> 0xF8.
//    Reset mid-OVF -> no irq, all regs 0.

Source files
------------

// File: rtl/gb_timer_pkg.sv
// Shared definitions for the DMG timer: register offsets, FSM states and the
// table that picks which counter bit clocks TIMA.
package gb_timer_pkg;

    localparam int CNT_WIDTH_DEF       = 16;
    localparam int OVF_DELAY_TICKS_DEF = 4;

    localparam logic [1:0] REG_DIV  = 2'd0;
    localparam logic [1:0] REG_TIMA = 2'd1;
    localparam logic [1:0] REG_TMA  = 2'd2;
    localparam logic [1:0] REG_TAC  = 2'd3;

    typedef enum logic {
        RUN = 1'b0,
        OVF = 1'b1
    } timer_state_t;

    // TAC[1:0] -> system counter bit whose falling edge advances TIMA
    function automatic logic [3:0] tac_bit_idx(input logic [1:0] clk_sel);
        logic [3:0] idx;
        case (clk_sel)
            2'b00:   idx = 4'd9;
            2'b01:   idx = 4'd3;
            2'b10:   idx = 4'd5;
            default: idx = 4'd7;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/gb_timer_if.sv
// CPU-side register bus of the timer plus its interrupt request line.
interface gb_timer_if;
    import gb_timer_pkg::*;

    logic [1:0] reg_sel;
    logic       wr_en;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       irq_timer;

    modport master (
        output reg_sel, wr_en, wdata,
        input  rdata, irq_timer
    );

    modport slave (
        input  reg_sel, wr_en, wdata,
        output rdata, irq_timer
    );
endinterface

// File: rtl/gb_timer_edge_det.sv
// Holds the previous TIMA clock level and flags a 1->0 transition.
module gb_timer_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic fall
);
    logic level_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_reg <= 1'b0;
        end else begin
            level_reg <= level;
        end
    end

    assign fall = level_reg & ~level;
endmodule

// File: rtl/gb_timer_unit.sv
// DMG timer: DIV system counter, TIMA/TMA/TAC and the delayed TMA reload with
// its interrupt pulse. All state advances on tick_en except register writes.
module gb_timer_unit
    import gb_timer_pkg::*;
#(
    parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
    parameter int OVF_DELAY_TICKS = OVF_DELAY_TICKS_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_en,
    gb_timer_if.slave  bus
);
    localparam int DELAY_W = $clog2(OVF_DELAY_TICKS + 1);
    localparam logic [DELAY_W-1:0] DELAY_INIT = DELAY_W'(OVF_DELAY_TICKS - 1);

    logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
    logic [7:0]           tima_reg, tima_next;
    logic [7:0]           tma_reg, tma_next;
    logic [2:0]           tac_reg, tac_next;
    logic [DELAY_W-1:0]   delay_reg, delay_next;
    logic [7:0]           rdata_reg, rdata_next;
    logic                 irq_reg, irq_next;
    timer_state_t         state_reg, state_next;

    logic div_wr, tima_wr, tma_wr, tac_wr;
    logic inc_sig, inc_pulse, reload;

    assign div_wr  = bus.wr_en && (bus.reg_sel == REG_DIV);
    assign tima_wr = bus.wr_en && (bus.reg_sel == REG_TIMA);
    assign tma_wr  = bus.wr_en && (bus.reg_sel == REG_TMA);
    assign tac_wr  = bus.wr_en && (bus.reg_sel == REG_TAC);

    // Any drop of this level counts, including ones caused by DIV/TAC writes
    assign inc_sig = tac_reg[2] & cnt_reg[tac_bit_idx(tac_reg[1:0])];

    gb_timer_edge_det u_edge_det (
        .clock (clock),
        .reset (reset),
        .level (inc_sig),
        .fall  (inc_pulse)
    );

    assign reload = (state_reg == OVF) && tick_en && (delay_reg == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= RUN;
            delay_reg <= '0;
            cnt_reg   <= '0;
            tima_reg  <= '0;
            tma_reg   <= '0;
            tac_reg   <= '0;
            rdata_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            delay_reg <= delay_next;
            cnt_reg   <= cnt_next;
            tima_reg  <= tima_next;
            tma_reg   <= tma_next;
            tac_reg   <= tac_next;
            rdata_reg <= rdata_next;
            irq_reg   <= irq_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        delay_next = delay_reg;
        case (state_reg)
            RUN: begin
                if (!tima_wr && inc_pulse && (tima_reg == 8'hFF)) begin
                    state_next = OVF;
                    delay_next = DELAY_INIT;
                end
            end
            OVF: begin
                if (reload || tima_wr) begin
                    state_next = RUN;
                    delay_next = '0;
                end else if (tick_en) begin
                    delay_next = delay_reg - 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        cnt_next  = cnt_reg;
        tma_next  = tma_wr ? bus.wdata : tma_reg;
        tac_next  = tac_wr ? bus.wdata[2:0] : tac_reg;
        tima_next = tima_reg;
        irq_next  = 1'b0;

        if (div_wr) begin
            cnt_next = '0;
        end else if (tick_en) begin
            cnt_next = cnt_reg + 1'b1;
        end

        // On the reload clock TMA (including a same-clock TMA write) beats a TIMA write
        if (reload) begin
            tima_next = tma_next;
            irq_next  = 1'b1;
        end else if (tima_wr) begin
            tima_next = bus.wdata;
        end else if (inc_pulse) begin
            tima_next = tima_reg + 8'd1;
        end

        case (bus.reg_sel)
            REG_DIV:  rdata_next = cnt_reg[CNT_WIDTH-1 -: 8];
            REG_TIMA: rdata_next = tima_reg;
            REG_TMA:  rdata_next = tma_reg;
            default:  rdata_next = {5'b11111, tac_reg};
        endcase
    end

    assign bus.rdata     = rdata_reg;
    assign bus.irq_timer = irq_reg;
endmodule

// File: tb/tb_gb_timer_unit.sv
// Directed bench for gb_timer_unit: counter, TIMA clocking, overflow reload and
// the write races around it.
module tb_gb_timer_unit;
    import gb_timer_pkg::*;

    logic clock = 1'b0;
    logic reset;
    logic tick_en;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] rv;

    gb_timer_if bus ();

    gb_timer_unit dut (
        .clock   (clock),
        .reset   (reset),
        .tick_en (tick_en),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic do_reset();
        reset       = 1'b1;
        tick_en     = 1'b0;
        bus.wr_en   = 1'b0;
        bus.reg_sel = REG_DIV;
        bus.wdata   = 8'h00;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        $display("reset");
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_en = 1'b1;
            @(posedge clock);
            #1 tick_en = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        tick_en = 1'b0;
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [7:0] data, input logic tk);
        bus.reg_sel = sel;
        bus.wdata   = data;
        bus.wr_en   = 1'b1;
        tick_en     = tk;
        @(posedge clock);
        #1;
        bus.wr_en   = 1'b0;
        tick_en     = 1'b0;
        $display("wr  sel=%0d data=%h tick=%0b", sel, data, tk);
    endtask

    task automatic rd(input logic [1:0] sel, output logic [7:0] val);
        bus.reg_sel = sel;
        bus.wr_en   = 1'b0;
        tick_en     = 1'b0;
        @(posedge clock);
        #1 val = bus.rdata;
        $display("rd  sel=%0d data=%h", sel, val);
    endtask

    task automatic setup_overflow();
        do_reset();
        wr(REG_TAC, 8'h05, 1'b0);
        wr(REG_TMA, 8'h80, 1'b0);
        wr(REG_TIMA, 8'hFE, 1'b0);
        tick(32);
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", bus.rdata); end
        checks++;
        if (bus.irq_timer !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", bus.irq_timer); end
        tick(512);
        rd(REG_DIV, rv);
        checks++;
        if (rv !== 8'h02) begin errors++; $display("FAIL div_512 got %h exp 02", rv); end
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL tima_tac0 got %h exp 00", rv); end
    endtask

    task automatic test_count();
        do_reset();
        wr(REG_TAC, 8'h05, 1'b0);
        wr(REG_TIMA, 8'h00, 1'b0);
        tick(160);
        idle(1);
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h0A) begin errors++; $display("FAIL tima_160 got %h exp 0a", rv); end
        tick(8);
        wr(REG_DIV, 8'h5A, 1'b0);
        idle(1);
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h0B) begin errors++; $display("FAIL tima_div_glitch got %h exp 0b", rv); end
        rd(REG_DIV, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL div_cleared got %h exp 00", rv); end
    endtask

    task automatic test_overflow();
        setup_overflow();
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL tima_ovf got %h exp 00", rv); end
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            checks++;
            if (bus.irq_timer !== (i == 4)) begin
                errors++;
                $display("FAIL irq_tick%0d got %b exp %b", i, bus.irq_timer, (i == 4));
            end
        end
        rd(REG_TIMA, rv);
        checks++;
        if (bus.irq_timer !== 1'b0) begin errors++; $display("FAIL irq_single got %b exp 0", bus.irq_timer); end
        checks++;
        if (rv !== 8'h80) begin errors++; $display("FAIL tima_reload got %h exp 80", rv); end
        rd(REG_TMA, rv);
        checks++;
        if (rv !== 8'h80) begin errors++; $display("FAIL tma_read got %h exp 80", rv); end
    endtask

    task automatic test_ovf_cancel();
        setup_overflow();
        tick(1);
        wr(REG_TIMA, 8'h33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            checks++;
            if (bus.irq_timer !== 1'b0) begin errors++; $display("FAIL cancel_irq%0d got %b exp 0", i, bus.irq_timer); end
        end
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h33) begin errors++; $display("FAIL cancel_tima got %h exp 33", rv); end
    endtask

    task automatic test_reload_race();
        setup_overflow();
        tick(3);
        wr(REG_TMA, 8'h44, 1'b1);
        checks++;
        if (bus.irq_timer !== 1'b1) begin errors++; $display("FAIL race_tma_irq got %b exp 1", bus.irq_timer); end
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h44) begin errors++; $display("FAIL race_tma_tima got %h exp 44", rv); end
        setup_overflow();
        tick(3);
        wr(REG_TIMA, 8'h55, 1'b1);
        checks++;
        if (bus.irq_timer !== 1'b1) begin errors++; $display("FAIL race_tima_irq got %b exp 1", bus.irq_timer); end
        rd(REG_TIMA, rv);
        checks++;
        if (bus.irq_timer !== 1'b0) begin errors++; $display("FAIL race_irq_single got %b exp 0", bus.irq_timer); end
        checks++;
        if (rv !== 8'h80) begin errors++; $display("FAIL race_tima_tima got %h exp 80", rv); end
    endtask

    task automatic test_tac_glitch();
        do_reset();
        tick(512);
        wr(REG_TAC, 8'h04, 1'b0);
        wr(REG_TAC, 8'h00, 1'b0);
        idle(1);
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h01) begin errors++; $display("FAIL tac_glitch got %h exp 01", rv); end
        rd(REG_TAC, rv);
        checks++;
        if (rv !== 8'hF8) begin errors++; $display("FAIL tac_read got %h exp f8", rv); end
        wr(REG_TAC, 8'h0B, 1'b0);
        rd(REG_TAC, rv);
        checks++;
        if (rv !== 8'hFB) begin errors++; $display("FAIL tac_mask got %h exp fb", rv); end
    endtask

    task automatic test_reset_mid_ovf();
        setup_overflow();
        tick(2);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick(1);
            checks++;
            if (bus.irq_timer !== 1'b0) begin errors++; $display("FAIL rst_ovf_irq%0d got %b exp 0", i, bus.irq_timer); end
        end
        rd(REG_TIMA, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL rst_tima got %h exp 00", rv); end
        rd(REG_TMA, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL rst_tma got %h exp 00", rv); end
        rd(REG_TAC, rv);
        checks++;
        if (rv !== 8'hF8) begin errors++; $display("FAIL rst_tac got %h exp f8", rv); end
        rd(REG_DIV, rv);
        checks++;
        if (rv !== 8'h00) begin errors++; $display("FAIL rst_div got %h exp 00", rv); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_overflow();
        test_ovf_cancel();
        test_reload_race();
        test_tac_glitch();
        test_reset_mid_ovf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
